gcd_operand_packer: RTL and testbench



---
 rtl/gcd_operand_packer.sv | 135 +++++++++++++
 tb/tb_gcd_operand_packer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_operand_packer.sv
// gcd_operand_packer
//   Upstream feeder for the GCD coprocessor. Pairs consecutive words of a
//   single-lane val/rdy stream into one (A, B) operand request and presents
//   it on the coprocessor operand port. A held A word can be discarded with
//   flush, and a wrapping counter reports how many pairs have been issued.
//
//   Optional build macro: GCD_PACKER_ORDER_EN
//     When defined, the pair is stored as A = max, B = min (unsigned compare)
//     on the edge that captures B. When undefined, words are stored in
//     arrival order and no comparator is built.
//
// Ports
//   clk             in   clock, all state updates on the rising edge
//   reset           in   asynchronous, active-high reset
//   in_val          in   stream word valid
//   in_rdy          out  packer can accept a stream word
//   in_bits         in   stream word [W-1:0]; first of a pair is A, second is B
//   flush           in   discard a held A word (only acts while one A is held)
//   operands_val    out  pair valid toward the coprocessor
//   operands_rdy    in   coprocessor accepts the pair
//   operands_bits_A out  operand A [W-1:0]
//   operands_bits_B out  operand B [W-1:0]
//   pair_count      out  pairs issued since reset, wraps modulo 2^CW

module gcd_operand_packer #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_val,
  output logic          in_rdy,
  input  logic [W-1:0]  in_bits,
  input  logic          flush,
  output logic          operands_val,
  input  logic          operands_rdy,
  output logic [W-1:0]  operands_bits_A,
  output logic [W-1:0]  operands_bits_B,
  output logic [CW-1:0] pair_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no word held
    HALF  = 2'd1,  // A held
    FULL  = 2'd2   // pair held and offered downstream
  } state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [CW-1:0] count_reg;

  logic          word_xfer;
  logic          pair_xfer;
  logic [W-1:0]  a_on_b;  // value A takes on the B capture edge
  logic [W-1:0]  b_on_b;  // value B takes on the B capture edge

  // In FULL the slot frees up exactly when the pair leaves, so readiness
  // follows operands_rdy combinationally; this lets the next A enter on the
  // same edge and keeps streaming bubble-free.
  assign in_rdy       = (state == FULL) ? operands_rdy : 1'b1;
  assign operands_val = (state == FULL);

  assign word_xfer = in_val & in_rdy;
  assign pair_xfer = operands_val & operands_rdy;

`ifdef GCD_PACKER_ORDER_EN
  logic swap;
  // Strict compare: equal values stay in arrival order (identical anyway).
  assign swap = in_bits > a_reg;

  always_comb begin
    a_on_b = a_reg;
    b_on_b = in_bits;
    if (swap) begin
      a_on_b = in_bits;
      b_on_b = a_reg;
    end
  end
`else
  always_comb begin
    a_on_b = a_reg;
    b_on_b = in_bits;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      a_reg     <= '0;
      b_reg     <= '0;
      count_reg <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (word_xfer) begin
            a_reg <= in_bits;
            state <= HALF;
          end
        end
        HALF: begin
          // flush wins: a word offered in the same cycle is accepted and dropped.
          if (flush) begin
            state <= EMPTY;
          end else if (word_xfer) begin
            a_reg <= a_on_b;
            b_reg <= b_on_b;
            state <= FULL;
          end
        end
        FULL: begin
          if (pair_xfer) begin
            count_reg <= count_reg + 1'b1;
            if (word_xfer) begin
              a_reg <= in_bits;
              state <= HALF;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Operand registers are visible only through FULL; outside it they still
  // read whatever was last captured (zero after reset).
  assign operands_bits_A = a_reg;
  assign operands_bits_B = b_reg;
  assign pair_count      = count_reg;

endmodule

// File: tb/tb_gcd_operand_packer.sv
// tb_gcd_operand_packer
//   Directed bench for gcd_operand_packer with W = 32 and CW = 4 so the
//   counter wrap is reachable quickly. Expected operand order follows the
//   GCD_PACKER_ORDER_EN build macro.

module tb_gcd_operand_packer;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [W-1:0]  in_bits;
  logic          flush;
  logic          operands_val;
  logic          operands_rdy;
  logic [W-1:0]  operands_bits_A;
  logic [W-1:0]  operands_bits_B;
  logic [CW-1:0] pair_count;

  int total = 0;
  int bad   = 0;
  int exp_pc = 0;

  gcd_operand_packer #(.W(W), .CW(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_val          (in_val),
    .in_rdy          (in_rdy),
    .in_bits         (in_bits),
    .flush           (flush),
    .operands_val    (operands_val),
    .operands_rdy    (operands_rdy),
    .operands_bits_A (operands_bits_A),
    .operands_bits_B (operands_bits_B),
    .pair_count      (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected A/B for a pair sent as (first, second).
  function automatic logic [W-1:0] exp_a(input logic [W-1:0] f, input logic [W-1:0] s);
`ifdef GCD_PACKER_ORDER_EN
    return (s > f) ? s : f;
`else
    return f;
`endif
  endfunction

  function automatic logic [W-1:0] exp_b(input logic [W-1:0] f, input logic [W-1:0] s);
`ifdef GCD_PACKER_ORDER_EN
    return (s > f) ? f : s;
`else
    return s;
`endif
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pair(input string tag, input logic [W-1:0] f, input logic [W-1:0] s);
    check({tag, "_val"}, {31'd0, operands_val}, 32'd1);
    check({tag, "_A"}, operands_bits_A, exp_a(f, s));
    check({tag, "_B"}, operands_bits_B, exp_b(f, s));
  endtask

  task automatic check_pc(input string tag);
    check(tag, {{(W-CW){1'b0}}, pair_count}, 32'(exp_pc % 16));
  endtask

  initial begin
    reset = 1'b1;
    in_val = 1'b0;
    in_bits = '0;
    flush = 1'b0;
    operands_rdy = 1'b0;
    #12;
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("rst_val", {31'd0, operands_val}, 32'd0);
    check("rst_A", operands_bits_A, 32'd0);
    check("rst_B", operands_bits_B, 32'd0);
    check_pc("rst_pc");

    // Basic pair 27, 15
    operands_rdy = 1'b1;
    in_val = 1'b1; in_bits = 27; tick();
    check("basic_half_val", {31'd0, operands_val}, 32'd0);
    in_bits = 15; tick();
    in_val = 1'b0;
    check_pair("basic", 27, 15);
    check("basic_in_rdy_full", {31'd0, in_rdy}, 32'd1);
    tick(); exp_pc++;
    check("basic_done_val", {31'd0, operands_val}, 32'd0);
    check_pc("basic_pc");

    // Reverse-order pair 15, 27
    in_val = 1'b1; in_bits = 15; tick();
    in_bits = 27; tick();
    in_val = 1'b0;
    check_pair("order", 15, 27);
    tick(); exp_pc++;
    check_pc("order_pc");

    // Backpressure: hold (8,12) for 5 cycles while 9 is offered
    operands_rdy = 1'b0;
    in_val = 1'b1; in_bits = 8; tick();
    in_bits = 12; tick();
    in_bits = 9;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
      check_pair("bp_hold", 8, 12);
      tick();
    end
    check_pc("bp_pc_held");
    operands_rdy = 1'b1;
    #1;
    check("bp_in_rdy_release", {31'd0, in_rdy}, 32'd1);
    tick(); exp_pc++;
    in_val = 1'b0;
    check("bp_after_val", {31'd0, operands_val}, 32'd0);
    check_pc("bp_pc");
    // 9 must be the held A: complete the pair with 100
    in_val = 1'b1; in_bits = 100; tick();
    in_val = 1'b0;
    check_pair("bp_next", 9, 100);
    tick(); exp_pc++;

    // Streaming 1..6 back-to-back
    in_val = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_bits = 32'(i);
      #1;
      check("stream_in_rdy", {31'd0, in_rdy}, 32'd1);
      tick();
      if (i % 2 == 0) begin
        check_pair("stream", 32'(i - 1), 32'(i));
      end else begin
        check("stream_odd_val", {31'd0, operands_val}, 32'd0);
        if (i > 1) exp_pc++;
        check_pc("stream_pc_mid");
      end
    end
    in_val = 1'b0;
    tick(); exp_pc++;
    check("stream_end_val", {31'd0, operands_val}, 32'd0);
    check_pc("stream_pc");

    // Flush: 42 held, then flush together with an offered 43 (dropped)
    in_val = 1'b1; in_bits = 42; tick();
    flush = 1'b1; in_bits = 43; tick();
    flush = 1'b0; in_val = 1'b0;
    check("flush_val", {31'd0, operands_val}, 32'd0);
    in_val = 1'b1; in_bits = 10; tick();
    check("flush_half_val", {31'd0, operands_val}, 32'd0);
    in_bits = 20; tick();
    in_val = 1'b0;
    check_pair("flush_pair", 10, 20);
    tick(); exp_pc++;
    check_pc("flush_pc");

    // Reset mid-operation while FULL with (5,7) under backpressure
    operands_rdy = 1'b0;
    in_val = 1'b1; in_bits = 5; tick();
    in_bits = 7; tick();
    in_val = 1'b0;
    check_pair("mid_full", 5, 7);
    #2;
    reset = 1'b1;
    #1;
    exp_pc = 0;
    check("mid_rst_val", {31'd0, operands_val}, 32'd0);
    check("mid_rst_A", operands_bits_A, 32'd0);
    check("mid_rst_B", operands_bits_B, 32'd0);
    check("mid_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    check_pc("mid_rst_pc");
    #1;
    reset = 1'b0;
    tick();
    operands_rdy = 1'b1;
    in_val = 1'b1; in_bits = 3; tick();
    in_bits = 11; tick();
    in_val = 1'b0;
    check_pair("mid_fresh", 3, 11);
    tick(); exp_pc++;
    check_pc("mid_fresh_pc");

    // Counter wrap: continue to 17 pairs total since reset
    for (int n = 2; n <= 17; n++) begin
      in_val = 1'b1; in_bits = 32'(2 * n); tick();
      in_bits = 32'(2 * n + 1); tick();
      in_val = 1'b0;
      tick(); exp_pc++;
      if (n >= 15) check_pc("wrap_pc");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
